// File: rtl/i2s_wave_pkg.sv
// Shared definitions for the I2S waveform sequencer.
//   - state_t     : sequencer FSM encoding (IDLE, FETCH, CAPTURE)
//   - DEF_*_WIDTH : default parameter widths
//   - FIFO_DEPTH  : number of entries in the output sample FIFO
package i2s_wave_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_POS_WIDTH   = 8;
  localparam int DEF_BURST_WIDTH = 16;
  localparam int FIFO_DEPTH      = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/wave_sample_fifo.sv
// Two-entry sample FIFO between the sequencer and the I2S transmit path.
// The head entry drives pop_data directly, so the output has no
// combinational dependency on pop.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   push, push_data     : write request and word
//   pop                 : consume head word (ignored when empty)
//   pop_data            : head word
//   full, empty         : occupancy flags
module wave_sample_fifo
  import i2s_wave_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_pop   = pop && !empty;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_wave_sequencer.sv
// Sine-table ROM sequencer: steps the ROM position, captures each sample
// after the ROM's one-cycle latency, and streams it out through a 2-entry
// FIFO with a valid/ready handshake.
// Optional build macro: WAVE_STEREO_EN -- every ROM sample is emitted twice
// (left then right) and sample_lr carries the channel tag per entry.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : level, starts/continues playback
//   step            : position increment per sample
//   burst_len       : samples (frames in stereo) per burst, 0 = continuous
//   rom_wavelength  : table length reported by the ROM
//   rom_pos         : registered ROM address
//   rom_value       : registered ROM data
//   sample_data/valid/ready/lr : output stream
//   busy            : FSM not idle
//   done            : one-cycle pulse at burst end
//   cfg_error       : sticky configuration error, cleared on start
module i2s_wave_sequencer
  import i2s_wave_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int POS_WIDTH   = DEF_POS_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [POS_WIDTH-1:0]   step,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic [POS_WIDTH-1:0]   rom_wavelength,
  output logic [POS_WIDTH-1:0]   rom_pos,
  input  logic [DATA_WIDTH-1:0]  rom_value,
  output logic [DATA_WIDTH-1:0]  sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   sample_lr,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_error
);

`ifdef WAVE_STEREO_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  state_t                 state;
  logic [BURST_WIDTH-1:0] counter;
  logic                   step_bad;
  logic [POS_WIDTH-1:0]   eff_step;
  logic [POS_WIDTH:0]     pos_sum;
  logic [POS_WIDTH-1:0]   next_pos;
  logic                   burst_end;
  logic                   last_push;
  logic                   fifo_push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FW-1:0]          push_word;
  logic [FW-1:0]          head_word;

  // An out-of-range step falls back to 1 so playback still makes progress.
  assign step_bad  = (step >= rom_wavelength);
  assign eff_step  = step_bad ? POS_WIDTH'(1) : step;
  assign pos_sum   = {1'b0, rom_pos} + {1'b0, eff_step};
  assign next_pos  = (pos_sum >= {1'b0, rom_wavelength})
                   ? POS_WIDTH'(pos_sum - {1'b0, rom_wavelength})
                   : pos_sum[POS_WIDTH-1:0];
  assign burst_end = (burst_len != '0) && ((counter + BURST_WIDTH'(1)) == burst_len);
  assign fifo_push = (state == CAPTURE) && !fifo_full;
  assign sample_valid = !fifo_empty;

`ifdef WAVE_STEREO_EN
  logic lr_phase;  // 0 = left copy pending, 1 = right copy pending
  assign last_push   = lr_phase;
  assign push_word   = {lr_phase, rom_value};
  assign sample_data = head_word[DATA_WIDTH-1:0];
  assign sample_lr   = !fifo_empty && head_word[DATA_WIDTH];
`else
  assign last_push   = 1'b1;
  assign push_word   = rom_value;
  assign sample_data = head_word;
  assign sample_lr   = 1'b0;
`endif

  wave_sample_fifo #(.WIDTH(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (sample_ready),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rom_pos   <= '0;
      counter   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_error <= 1'b0;
`ifdef WAVE_STEREO_EN
      lr_phase  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            if (rom_wavelength == '0) begin
              cfg_error <= 1'b1;
            end else begin
              rom_pos   <= '0;
              counter   <= '0;
              cfg_error <= 1'b0;
              busy      <= 1'b1;
              state     <= FETCH;
`ifdef WAVE_STEREO_EN
              lr_phase  <= 1'b0;
`endif
            end
          end
        end
        FETCH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          // While full, rom_pos is held so rom_value stays valid for the retry.
          if (!fifo_full) begin
            if (!last_push) begin
`ifdef WAVE_STEREO_EN
              lr_phase <= 1'b1;
`endif
            end else begin
`ifdef WAVE_STEREO_EN
              lr_phase <= 1'b0;
`endif
              counter <= counter + BURST_WIDTH'(1);
              rom_pos <= next_pos;
              if (step_bad) cfg_error <= 1'b1;
              if (burst_end) begin
                state <= IDLE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else if (!enable) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= FETCH;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_wave_sequencer.sv
// Scoreboard bench for i2s_wave_sequencer with a behavioural registered ROM.
module tb_i2s_wave_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  step;
  logic [15:0] burst_len;
  logic [7:0]  rom_wavelength;
  logic [7:0]  rom_pos;
  logic [15:0] rom_value;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_lr;
  logic        busy;
  logic        done;
  logic        cfg_error;

  typedef struct packed {
    logic        lr;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  logic [15:0] rom_tab [256];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  bit          strict   = 1'b1;

  always #5 clk = ~clk;

  i2s_wave_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .step           (step),
    .burst_len      (burst_len),
    .rom_wavelength (rom_wavelength),
    .rom_pos        (rom_pos),
    .rom_value      (rom_value),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .sample_lr      (sample_lr),
    .busy           (busy),
    .done           (done),
    .cfg_error      (cfg_error)
  );

  // ROM model: one-cycle registered read.
  always @(posedge clk) rom_value <= rom_tab[rom_pos];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares every handshake against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      chk("busy_at_done", 32'(busy), 32'd0);
    end
    if (!rst && sample_valid && sample_ready) begin
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sample_data", 32'(sample_data), 32'(e.data));
        chk("sample_lr", 32'(sample_lr), 32'(e.lr));
        $display("sample data=%04h lr=%0d (exp %04h/%0d)", sample_data, sample_lr, e.data, e.lr);
      end else if (strict) begin
        chk("unexpected_sample", 32'd1, 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected stream: positions advance by step modulo wavelength (step 1 if out of range).
  task automatic push_run(input int wl, input int stp, input int n, input bit stereo);
    int p = 0;
    int s;
    s = (stp >= wl) ? 1 : stp;
    for (int i = 0; i < n; i++) begin
      q.push_back('{lr: 1'b0, data: rom_tab[p]});
      if (stereo) q.push_back('{lr: 1'b1, data: rom_tab[p]});
      p = (p + s) % wl;
    end
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (q.size() != 0 && t < budget) begin
      tick(1);
      t++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!done && t < budget) begin
      tick(1);
      t++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic stop_and_reset();
    strict = 1'b0;
    enable = 1'b0;
    tick(8);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    q.delete();
    strict = 1'b1;
    done_cnt = 0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < 256; i++) rom_tab[i] = 16'hA000 + 16'(i);
    rom_tab[0] = 16'h0000;
    rom_tab[1] = 16'h1237;
    rom_tab[2] = 16'h240F;
    rom_tab[3] = 16'h352C;

    rst = 1'b1; enable = 1'b0; step = 8'd1; burst_len = 16'd0;
    rom_wavelength = 8'd44; sample_ready = 1'b0;
    tick(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_pos", 32'(rom_pos), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_error", 32'(cfg_error), 32'd0);
    chk("rst_lr", 32'(sample_lr), 32'd0);
    rst = 1'b0;
    tick(1);

    // Continuous, step 1: full table plus wrap back to 0, 1.
    sample_ready = 1'b1;
    push_run(44, 1, 46, 1'b0);
    enable = 1'b1;
    t = 0;
    while (rom_pos != 8'd43 && t < 200) begin tick(1); t++; end
    chk("reach_pos43", 32'(rom_pos), 32'd43);
    t = 0;
    while (rom_pos == 8'd43 && t < 20) begin tick(1); t++; end
    chk("wrap_pos", 32'(rom_pos), 32'd0);
    wait_drain(300);
    stop_and_reset();

    // Step 3: 0,3,...,42 then 45-44 = 1, 4.
    step = 8'd3;
    push_run(44, 3, 16, 1'b0);
    enable = 1'b1;
    wait_drain(200);
    chk("step3_cfg_error", 32'(cfg_error), 32'd0);
    stop_and_reset();

    // Step equal to wavelength: falls back to step 1 and flags cfg_error.
    step = 8'd44;
    push_run(44, 44, 4, 1'b0);
    enable = 1'b1;
    wait_drain(100);
    chk("step44_cfg_error", 32'(cfg_error), 32'd1);
    stop_and_reset();

    // Zero wavelength: error, stays idle; a valid start clears it.
    step = 8'd1;
    strict = 1'b0;
    rom_wavelength = 8'd0;
    enable = 1'b1;
    tick(3);
    chk("wl0_cfg_error", 32'(cfg_error), 32'd1);
    chk("wl0_busy", 32'(busy), 32'd0);
    rom_wavelength = 8'd44;
    tick(2);
    chk("restart_cfg_clear", 32'(cfg_error), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    stop_and_reset();

    // Burst of 5.
    burst_len = 16'd5;
    push_run(44, 1, 5, 1'b0);
    enable = 1'b1;
    wait_done(100);
    enable = 1'b0;
    tick(10);
    chk("burst_done_count", 32'(done_cnt), 32'd1);
    chk("burst_idle", 32'(busy), 32'd0);
    chk("burst_all_seen", 32'(q.size()), 32'd0);
    burst_len = 16'd0;
    stop_and_reset();

    // Backpressure: FIFO fills with pos 0,1; FSM stalls with rom_pos = 2.
    sample_ready = 1'b0;
    push_run(44, 1, 6, 1'b0);
    enable = 1'b1;
    tick(10);
    chk("bp_pos_a", 32'(rom_pos), 32'd2);
    tick(10);
    chk("bp_pos_b", 32'(rom_pos), 32'd2);
    chk("bp_valid", 32'(sample_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    sample_ready = 1'b1;
    wait_drain(100);
    stop_and_reset();

    // Asynchronous reset while stalled with a full FIFO.
    sample_ready = 1'b0;
    enable = 1'b1;
    tick(10);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(sample_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pos", 32'(rom_pos), 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    push_run(44, 1, 3, 1'b0);
    sample_ready = 1'b1;
    wait_drain(100);
    stop_and_reset();

`ifdef WAVE_STEREO_EN
    // Stereo burst of 2 frames: L/R pairs, then done.
    burst_len = 16'd2;
    push_run(44, 1, 2, 1'b1);
    enable = 1'b1;
    wait_done(100);
    enable = 1'b0;
    tick(10);
    chk("stereo_done_count", 32'(done_cnt), 32'd1);
    chk("stereo_all_seen", 32'(q.size()), 32'd0);
    burst_len = 16'd0;
    stop_and_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
